// File: rtl/vga_scanout.sv
// vga_scanout: 640x480 VGA timing generator with 2x line-doubled scan-out.
// Counters run on the pixel clock. One line-fetch request per source line
// (plus a trailing dummy) goes to the frame-buffer controller. BGR555 read
// data is expanded to 24-bit RGB through a 2-stage registered pipeline that
// also delays hsync/vsync/de so they stay aligned with the pixels.
// Optional build macro SCANLINE_EN halves odd display lines in the picture.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SRC_W    = 256,
  parameter int SRC_H    = 224,
  parameter int X_OFS    = 64,
  parameter int Y_OFS    = 16,
  parameter int REQ_LEN  = 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        r_req,
  output logic [8:0]  r_y,
  output logic [8:0]  r_x,
  input  logic [14:0] r_color,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG    = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG    = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] X_BEG     = 10'(X_OFS);
  localparam logic [9:0] X_END     = 10'(X_OFS + 2 * SRC_W);
  localparam logic [9:0] Y_BEG     = 10'(Y_OFS);
  localparam logic [9:0] Y_END     = 10'(Y_OFS + 2 * SRC_H);
  // Request j lands on line Y_OFS+2j-3 so source line k is readable
  // before display line Y_OFS+2k; j=SRC_H is the dummy that retires the last line.
  localparam logic [9:0] REQ_FIRST = 10'(Y_OFS - 3);
  localparam logic [9:0] REQ_LAST  = 10'(Y_OFS + 2 * SRC_H - 3);
  localparam logic [9:0] REQ_H_END = 10'(H_ACTIVE + REQ_LEN);
  localparam logic [8:0] SRC_H_Y   = 9'(SRC_H);

  // Stage 0 state: counters and request outputs
  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic       r_req_q, r_req_d;
  logic [8:0] r_y_q, r_y_d;
  logic [9:0] req_off;
  logic [8:0] req_idx;
  logic       req_line;

  // Stage 1 state
  logic [8:0] r_x_q, r_x_d;
  logic       pic1_q, pic1_d;
  logic       hs1_q, hs1_d;
  logic       vs1_q, vs1_d;
  logic       de1_q, de1_d;
`ifdef SCANLINE_EN
  logic       odd1_q;
`endif

  // Stage 2 state (module outputs)
  logic [7:0] r_q, g_q, b_q;
  logic [7:0] r_d, g_d, b_d;
  logic       hs_q, vs_q, de_q;

  // Next counter position and the request decode evaluated against it, so
  // r_req/r_y are registered yet line up with the counter they belong to.
  always_comb begin
    hcnt_d = hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
    end
    req_off  = vcnt_d - REQ_FIRST;
    req_idx  = 9'(req_off >> 1);
    req_line = (vcnt_d >= REQ_FIRST) && (vcnt_d <= REQ_LAST) && !req_off[0];
    r_req_d  = req_line && (hcnt_d >= H_ACT) && (hcnt_d < REQ_H_END);
    r_y_d    = r_y_q;
    if (req_line && (hcnt_d == H_ACT))
      r_y_d = (req_idx == SRC_H_Y) ? 9'd0 : req_idx;
  end

  // Stage 0 registers: raster counters and line-fetch request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      r_req_q <= 1'b0;
      r_y_q   <= '0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      r_req_q <= r_req_d;
      r_y_q   <= r_y_d;
    end
  end

  // Stage 1 decode: read-buffer column, picture flag and raw syncs
  always_comb begin
    pic1_d = (hcnt_q >= X_BEG) && (hcnt_q < X_END) &&
             (vcnt_q >= Y_BEG) && (vcnt_q < Y_END);
    r_x_d  = pic1_d ? 9'((hcnt_q - X_BEG) >> 1) : 9'd0;
    hs1_d  = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
    vs1_d  = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
    de1_d  = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
  end

  // Stage 1 registers: drive r_x and delay control flags by one clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x_q  <= '0;
      pic1_q <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      de1_q  <= 1'b0;
`ifdef SCANLINE_EN
      odd1_q <= 1'b0;
`endif
    end else begin
      r_x_q  <= r_x_d;
      pic1_q <= pic1_d;
      hs1_q  <= hs1_d;
      vs1_q  <= vs1_d;
      de1_q  <= de1_d;
`ifdef SCANLINE_EN
      odd1_q <= vcnt_q[0];
`endif
    end
  end

  // Stage 2 colour expansion: 5-bit channel -> 8 bits by replicating MSBs
  always_comb begin
    r_d = 8'd0;
    g_d = 8'd0;
    b_d = 8'd0;
    if (pic1_q) begin
      r_d = {r_color[4:0],   r_color[4:2]};
      g_d = {r_color[9:5],   r_color[9:7]};
      b_d = {r_color[14:10], r_color[14:12]};
`ifdef SCANLINE_EN
      if (odd1_q) begin
        r_d = r_d >> 1;
        g_d = g_d >> 1;
        b_d = b_d >> 1;
      end
`endif
    end
  end

  // Stage 2 registers: pixel data and syncs leave together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      de_q <= 1'b0;
    end else begin
      r_q  <= r_d;
      g_q  <= g_d;
      b_q  <= b_d;
      hs_q <= hs1_q;
      vs_q <= vs1_q;
      de_q <= de1_q;
    end
  end

  assign r_req  = r_req_q;
  assign r_y    = r_y_q;
  assign r_x    = r_x_q;
  assign vga_r  = r_q;
  assign vga_g  = g_q;
  assign vga_b  = b_q;
  assign vga_hs = hs_q;
  assign vga_vs = vs_q;
  assign vga_de = de_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a reduced raster geometry (same rules, small
// numbers) so several frames fit in a short run. A reference model computes
// each cycle's expected outputs from the raster position; a monitor process
// pops and compares them at every falling edge.
module tb_vga_scanout;

  localparam int HA = 48, HFP = 4, HSW = 8, HBP = 4;
  localparam int VA = 32, VFP = 2, VSW = 2, VBP = 3;
  localparam int SW = 16, SH = 10;
  localparam int XO = (HA - 2 * SW) / 2;
  localparam int YO = (VA - 2 * SH) / 2;
  localparam int RL = 1;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FR = HT * VT;
  localparam logic [26:0] RST_PIX = {24'h0, 1'b1, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        r_req;
  logic [8:0]  r_y;
  logic [8:0]  r_x;
  logic [14:0] r_color;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_de;

  // Read buffer model: settled data for the addressed column
  logic [14:0] mem [0:511];
  assign r_color = mem[r_x];

  // Clock/reset block
  always #5 clk = ~clk;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .SRC_W(SW), .SRC_H(SH), .X_OFS(XO), .Y_OFS(YO), .REQ_LEN(RL)
  ) dut (
    .clk(clk), .reset(reset),
    .r_req(r_req), .r_y(r_y), .r_x(r_x), .r_color(r_color),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int req_seen = 0;
  int de_seen = 0;
  logic [8:0] y_hold = '0;
  logic [26:0] pix_q[$];
  logic [9:0]  req_q[$];

  // 5-bit channel to 8 bits by plain arithmetic
  function automatic logic [7:0] expand(input int c5, input int v);
    int x;
    x = c5 * 8 + c5 / 4;
`ifdef SCANLINE_EN
    if (v % 2 == 1) x = x / 2;
`endif
    return 8'(x);
  endfunction

  function automatic logic [26:0] model_pix(input int h, input int v);
    logic de, hs, vs;
    logic [7:0] r, g, b;
    int c;
    de = (h < HA) && (v < VA);
    hs = !((h >= HA + HFP) && (h < HA + HFP + HSW));
    vs = !((v >= VA + VFP) && (v < VA + VFP + VSW));
    r = 0; g = 0; b = 0;
    if (h >= XO && h < XO + 2 * SW && v >= YO && v < YO + 2 * SH) begin
      c = int'(mem[(h - XO) / 2]);
      r = expand(c % 32, v);
      g = expand((c / 32) % 32, v);
      b = expand(c / 1024, v);
    end
    return {r, g, b, hs, vs, de};
  endfunction

  // Push expectations for the raster position the DUT holds this cycle
  task automatic push_cycle();
    int h, v, j;
    logic rq;
    h = cyc % HT;
    v = (cyc / HT) % VT;
    pix_q.push_back(model_pix(h, v));
    rq = (h >= HA) && (h < HA + RL) && (v >= YO - 3) && (v <= YO + 2 * SH - 3) &&
         ((v - (YO - 3)) % 2 == 0);
    if (rq && h == HA) begin
      j = (v - (YO - 3)) / 2;
      y_hold = (j < SH) ? 9'(j) : 9'd0;
    end
    req_q.push_back({rq, y_hold});
  endtask

  task automatic check_frame();
    total++;
    if (req_seen != SH + 1) begin
      bad++;
      $display("FAIL frame_reqs got=%0d exp=%0d", req_seen, SH + 1);
    end
    total++;
    if (de_seen != HA * VA) begin
      bad++;
      $display("FAIL frame_de got=%0d exp=%0d", de_seen, HA * VA);
    end
    req_seen = 0;
    de_seen = 0;
  endtask

  task automatic check_reset_vals(input string name);
    logic [50:0] got;
    logic [50:0] exp;
    got = {r_req, r_y, r_x, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de};
    exp = {1'b0, 9'd0, 9'd0, 24'd0, 1'b1, 1'b1, 1'b0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL reset_%s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Driver: release reset just after a rising edge; first cycle is position 0
  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    y_hold = '0;
    pix_q.delete();
    req_q.delete();
    pix_q.push_back(RST_PIX);
    pix_q.push_back(RST_PIX);
    push_cycle();
    req_seen = 0;
    de_seen = 0;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (cyc % FR == 0) check_frame();
    push_cycle();
    // New random picture content during vertical blanking only
    if (cyc % FR == VA * HT)
      for (int i = 0; i < SW; i++) mem[i] = 15'($urandom_range(0, 32767));
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [26:0] ep;
    logic [9:0]  er;
    if (!reset) begin
      if (req_q.size() >= 1) begin
        er = req_q.pop_front();
        total++;
        if ({r_req, r_y} !== er) begin
          bad++;
          $display("FAIL req t=%0t got=%b/%0d exp=%b/%0d", $time, r_req, r_y, er[9], er[8:0]);
        end
        if (r_req) req_seen++;
      end
      if (pix_q.size() >= 3) begin
        ep = pix_q.pop_front();
        total++;
        if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de} !== ep) begin
          bad++;
          $display("FAIL pix t=%0t got=%h%h%h hs%b vs%b de%b exp=%h hs%b vs%b de%b",
                   $time, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de,
                   ep[26:3], ep[2], ep[1], ep[0]);
        end
        if (vga_de) de_seen++;
      end
    end
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 15'($urandom_range(0, 32767));
    mem[0] = 15'h7FFF;
    mem[1] = 15'h0010;
    mem[2] = 15'h7C00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("power_on");
    release_reset();
    // Two full frames
    while (cyc < 2 * FR) step();
    // Run into the third frame, then reset mid-line inside the picture
    while (cyc < 2 * FR + 15 * HT + 20) step();
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_reset_vals("async");
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("held");
    release_reset();
    while (cyc < FR + 2 * HT) step();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
